// File: rtl/mem_access_module_pkg.sv
// Shared encodings and small helpers for the MEM stage: access-width codes,
// write-back select codes, alignment check and byte-lane enable generation.
package mem_access_module_pkg;

  localparam logic [1:0] WIDTH_BYTE    = 2'b00;
  localparam logic [1:0] WIDTH_HALF    = 2'b01;
  localparam logic [1:0] WIDTH_WORD    = 2'b11;

  localparam logic       DATA_FROM_MEM = 1'b1;
  localparam logic       DATA_FROM_ALU = 1'b0;

  // A halfword must sit on an even byte, a word on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    logic result;
    case (width)
      WIDTH_HALF: result = offset[0];
      WIDTH_WORD: result = (offset != 2'b00);
      default:    result = 1'b0;
    endcase
    return result;
  endfunction

  // Little-endian byte lanes touched by an access of the given width/offset.
  function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] offset);
    logic [3:0] result;
    case (width)
      WIDTH_BYTE: result = 4'b0001 << offset;
      WIDTH_HALF: result = 4'b0011 << offset;
      WIDTH_WORD: result = 4'b1111;
      default:    result = 4'b0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_access_module_data_memory.sv
// Single-port data memory with four byte-lane write enables, a read-first
// registered read port and an asynchronous debug read port. Contents are not
// reset; only the read register is.
module data_memory_module #(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_read_en,
  input  logic [3:0]         i_byte_en,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_BITS-1:0] i_wdata,
  output logic [NB_BITS-1:0] o_rdata,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_BITS-1:0] o_debug_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_BITS-1:0] mem_r [DEPTH];
  logic [NB_BITS-1:0] rdata_r;

  // Byte-lane writes into the array; lanes with a clear enable keep their value.
  always_ff @(posedge i_clock) begin
    for (int i = 0; i < 4; i++) begin
      if (i_byte_en[i]) begin
        mem_r[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  // Registered read; sampling before the write lands gives read-first behaviour.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rdata_r <= {NB_BITS{1'b0}};
    end else if (i_read_en) begin
      rdata_r <= mem_r[i_addr];
    end
  end

  assign o_rdata      = rdata_r;
  assign o_debug_data = mem_r[i_debug_addr];

endmodule

// File: rtl/mem_access_module.sv
// MIPS MEM stage with the MEM/WB pipeline register: byte/half/word loads and
// stores on local data memory, alignment detection, load formatting.
module mem_access_module
  import mem_access_module_pkg::*;
#(
  parameter int NB_BITS     = 32,
  parameter int NB_ADDR     = 10,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic [NB_BITS-1:0]     i_alu_result,
  input  logic [NB_BITS-1:0]     i_store_data,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_width,
  input  logic                   i_unsigned,
  input  logic                   i_reg_write,
  input  logic                   i_mem_to_reg,
  input  logic [NB_REG_ADDR-1:0] i_rd_addr,
  input  logic [NB_ADDR-1:0]     i_debug_addr,
  output logic [NB_BITS-1:0]     o_mem_data,
  output logic [NB_BITS-1:0]     o_alu_data,
  output logic                   o_mem_to_reg,
  output logic                   o_reg_write,
  output logic [NB_REG_ADDR-1:0] o_rd_addr,
  output logic                   o_misaligned,
  output logic [NB_BITS-1:0]     o_debug_data
);

  logic [NB_ADDR-1:0] word_addr_s;
  logic [1:0]         offset_s;
  logic               misaligned_s;
  logic               store_s;
  logic               load_s;
  logic [3:0]         byte_en_s;
  logic [NB_BITS-1:0] lane_data_s;
  logic [NB_BITS-1:0] rdata_s;

  logic [1:0]         offset_r;
  logic [1:0]         width_r;
  logic               unsigned_r;

  logic [7:0]         byte_s;
  logic [15:0]        half_s;
  logic [NB_BITS-1:0] mem_data_s;

  assign word_addr_s  = i_alu_result[NB_ADDR+1:2];
  assign offset_s     = i_alu_result[1:0];
  assign misaligned_s = (i_mem_read | i_mem_write) & is_misaligned(i_width, offset_s);
  assign store_s      = i_enable & ~i_flush & i_mem_write & ~misaligned_s;
  assign load_s       = i_enable & i_mem_read;
  assign byte_en_s    = store_s ? lane_enables(i_width, offset_s) : 4'b0000;

  // Replicate the store operand so every addressed lane carries the right bytes.
  always_comb begin
    lane_data_s = i_store_data;
    case (i_width)
      WIDTH_BYTE: lane_data_s = {4{i_store_data[7:0]}};
      WIDTH_HALF: lane_data_s = {2{i_store_data[15:0]}};
      WIDTH_WORD: lane_data_s = i_store_data;
      default:    lane_data_s = i_store_data;
    endcase
  end

  data_memory_module #(
    .NB_BITS (NB_BITS),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_read_en    (load_s),
    .i_byte_en    (byte_en_s),
    .i_addr       (word_addr_s),
    .i_wdata      (lane_data_s),
    .o_rdata      (rdata_s),
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data)
  );

  // Latch the load format alongside the registered memory word.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      offset_r   <= 2'b00;
      width_r    <= 2'b00;
      unsigned_r <= 1'b0;
    end else if (load_s) begin
      offset_r   <= offset_s;
      width_r    <= i_width;
      unsigned_r <= i_unsigned;
    end
  end

  // MEM/WB register; a flush inserts a bubble, a stall holds everything.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_data   <= {NB_BITS{1'b0}};
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_rd_addr    <= {NB_REG_ADDR{1'b0}};
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_alu_data   <= i_alu_result;
      o_mem_to_reg <= i_mem_to_reg;
      o_rd_addr    <= i_rd_addr;
      if (i_flush) begin
        o_reg_write  <= 1'b0;
        o_misaligned <= 1'b0;
      end else begin
        o_reg_write  <= i_reg_write & ~misaligned_s;
        o_misaligned <= misaligned_s;
      end
    end
  end

  // Extract the addressed byte/half from the registered word and extend it.
  always_comb begin
    byte_s     = 8'h00;
    half_s     = offset_r[1] ? rdata_s[31:16] : rdata_s[15:0];
    mem_data_s = rdata_s;
    case (offset_r)
      2'b00:   byte_s = rdata_s[7:0];
      2'b01:   byte_s = rdata_s[15:8];
      2'b10:   byte_s = rdata_s[23:16];
      2'b11:   byte_s = rdata_s[31:24];
      default: byte_s = rdata_s[7:0];
    endcase
    case (width_r)
      WIDTH_BYTE: mem_data_s = unsigned_r ? {{(NB_BITS-8){1'b0}}, byte_s}
                                          : {{(NB_BITS-8){byte_s[7]}}, byte_s};
      WIDTH_HALF: mem_data_s = unsigned_r ? {{(NB_BITS-16){1'b0}}, half_s}
                                          : {{(NB_BITS-16){half_s[15]}}, half_s};
      WIDTH_WORD: mem_data_s = rdata_s;
      default:    mem_data_s = rdata_s;
    endcase
  end

  assign o_mem_data = mem_data_s;

endmodule

// File: tb/tb_mem_access_module.sv
// Directed testbench for mem_access_module: hand-computed loads, stores,
// alignment, stall, flush, read-first and asynchronous reset behaviour.
module tb_mem_access_module;
  import mem_access_module_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b1;
  logic        i_flush = 1'b0;
  logic [31:0] i_alu_result = 32'h0;
  logic [31:0] i_store_data = 32'h0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_width = 2'b00;
  logic        i_unsigned = 1'b0;
  logic        i_reg_write = 1'b0;
  logic        i_mem_to_reg = 1'b0;
  logic [4:0]  i_rd_addr = 5'd0;
  logic [9:0]  i_debug_addr = 10'd0;
  logic [31:0] o_mem_data;
  logic [31:0] o_alu_data;
  logic        o_mem_to_reg;
  logic        o_reg_write;
  logic [4:0]  o_rd_addr;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  int errors = 0;
  int checks = 0;

  mem_access_module dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_flush      (i_flush),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_width      (i_width),
    .i_unsigned   (i_unsigned),
    .i_reg_write  (i_reg_write),
    .i_mem_to_reg (i_mem_to_reg),
    .i_rd_addr    (i_rd_addr),
    .i_debug_addr (i_debug_addr),
    .o_mem_data   (o_mem_data),
    .o_alu_data   (o_alu_data),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_rd_addr    (o_rd_addr),
    .o_misaligned (o_misaligned),
    .o_debug_data (o_debug_data)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [31:0] addr, input logic [31:0] sdata, input logic rd,
                       input logic wr, input logic [1:0] w, input logic uns, input logic rw,
                       input logic m2r, input logic [4:0] rda);
    i_alu_result = addr;
    i_store_data = sdata;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_width      = w;
    i_unsigned   = uns;
    i_reg_write  = rw;
    i_mem_to_reg = m2r;
    i_rd_addr    = rda;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_mem_data", o_mem_data, 32'h0);
    chk("rst_alu_data", o_alu_data, 32'h0);
    chk("rst_reg_write", {31'h0, o_reg_write}, 32'h0);
    chk("rst_rd_addr", {27'h0, o_rd_addr}, 32'h0);
    chk("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
    @(negedge i_clock);
    i_reset = 1'b1;

    // SW 0x8000_00FF @0x10
    instr(32'h10, 32'h8000_00FF, 1'b0, 1'b1, WIDTH_WORD, 1'b0, 1'b0, DATA_FROM_ALU, 5'd0);
    tick();
    chk("sw_reg_write", {31'h0, o_reg_write}, 32'h0);
    chk("sw_alu_data", o_alu_data, 32'h10);

    // LW @0x10
    instr(32'h10, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd5);
    tick();
    chk("lw_data", o_mem_data, 32'h8000_00FF);
    chk("lw_reg_write", {31'h0, o_reg_write}, 32'h1);
    chk("lw_mem_to_reg", {31'h0, o_mem_to_reg}, {31'h0, DATA_FROM_MEM});
    chk("lw_rd_addr", {27'h0, o_rd_addr}, 32'd5);

    instr(32'h13, 32'h0, 1'b1, 1'b0, WIDTH_BYTE, 1'b0, 1'b1, DATA_FROM_MEM, 5'd6);
    tick();
    chk("lb_13", o_mem_data, 32'hFFFF_FF80);
    instr(32'h13, 32'h0, 1'b1, 1'b0, WIDTH_BYTE, 1'b1, 1'b1, DATA_FROM_MEM, 5'd6);
    tick();
    chk("lbu_13", o_mem_data, 32'h0000_0080);
    instr(32'h10, 32'h0, 1'b1, 1'b0, WIDTH_HALF, 1'b0, 1'b1, DATA_FROM_MEM, 5'd6);
    tick();
    chk("lh_10", o_mem_data, 32'h0000_00FF);

    // SB 0xAB @0x11 then LW
    instr(32'h11, 32'h1234_56AB, 1'b0, 1'b1, WIDTH_BYTE, 1'b0, 1'b0, DATA_FROM_ALU, 5'd0);
    tick();
    instr(32'h10, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd7);
    tick();
    chk("sb_lw_10", o_mem_data, 32'h8000_ABFF);
    i_debug_addr = 10'd4;
    #1;
    chk("dbg_word4", o_debug_data, 32'h8000_ABFF);

    // Upper-half loads
    instr(32'h12, 32'h0, 1'b1, 1'b0, WIDTH_HALF, 1'b0, 1'b1, DATA_FROM_MEM, 5'd8);
    tick();
    chk("lh_12", o_mem_data, 32'hFFFF_8000);
    instr(32'h12, 32'h0, 1'b1, 1'b0, WIDTH_HALF, 1'b1, 1'b1, DATA_FROM_MEM, 5'd8);
    tick();
    chk("lhu_12", o_mem_data, 32'h0000_8000);

    // Misaligned accesses
    instr(32'h12, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd9);
    tick();
    chk("lw_12_mis", {31'h0, o_misaligned}, 32'h1);
    chk("lw_12_rw", {31'h0, o_reg_write}, 32'h0);
    instr(32'h11, 32'h0000_BEEF, 1'b0, 1'b1, WIDTH_HALF, 1'b0, 1'b0, DATA_FROM_ALU, 5'd0);
    tick();
    chk("sh_11_mis", {31'h0, o_misaligned}, 32'h1);
    chk("sh_11_rw", {31'h0, o_reg_write}, 32'h0);
    instr(32'h10, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd10);
    tick();
    chk("lw_after_mis", o_mem_data, 32'h8000_ABFF);
    chk("lw_after_mis_flag", {31'h0, o_misaligned}, 32'h0);

    // Stall with a store on the inputs
    instr(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, WIDTH_WORD, 1'b0, 1'b0, DATA_FROM_ALU, 5'd11);
    i_alu_result = 32'h14;
    i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_mem_data", o_mem_data, 32'h8000_ABFF);
      chk("stall_alu_data", o_alu_data, 32'h10);
      chk("stall_reg_write", {31'h0, o_reg_write}, 32'h1);
      chk("stall_rd_addr", {27'h0, o_rd_addr}, 32'd10);
    end
    chk("stall_dbg_word4", o_debug_data, 32'h8000_ABFF);
    i_debug_addr = 10'd5;
    #1;
    chk("stall_dbg_word5", o_debug_data === 32'hDEAD_BEEF ? 32'h1 : 32'h0, 32'h0);
    i_enable = 1'b1;

    // Read-during-write, read-first
    instr(32'h20, 32'h1111_2222, 1'b0, 1'b1, WIDTH_WORD, 1'b0, 1'b0, DATA_FROM_ALU, 5'd0);
    tick();
    instr(32'h20, 32'h1234_5678, 1'b1, 1'b1, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd12);
    tick();
    chk("rdw_old", o_mem_data, 32'h1111_2222);
    instr(32'h20, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd12);
    tick();
    chk("rdw_new", o_mem_data, 32'h1234_5678);

    // Flush suppresses store and reg_write, and clears misaligned
    i_flush = 1'b1;
    instr(32'h20, 32'hCAFE_F00D, 1'b0, 1'b1, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_ALU, 5'd13);
    tick();
    chk("flush_rw", {31'h0, o_reg_write}, 32'h0);
    i_debug_addr = 10'd8;
    #1;
    chk("flush_no_store", o_debug_data, 32'h1234_5678);
    instr(32'h22, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd13);
    tick();
    chk("flush_mis", {31'h0, o_misaligned}, 32'h0);
    chk("flush_mis_rw", {31'h0, o_reg_write}, 32'h0);
    i_flush = 1'b0;

    // Non-memory instruction with an odd ALU result never flags misaligned
    instr(32'h13, 32'h0, 1'b0, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_ALU, 5'd14);
    tick();
    chk("alu_mis", {31'h0, o_misaligned}, 32'h0);
    chk("alu_rw", {31'h0, o_reg_write}, 32'h1);
    chk("alu_data", o_alu_data, 32'h13);
    chk("alu_m2r", {31'h0, o_mem_to_reg}, {31'h0, DATA_FROM_ALU});

    // Asynchronous reset mid-stream, away from the edge
    instr(32'h20, 32'h0, 1'b1, 1'b0, WIDTH_WORD, 1'b0, 1'b1, DATA_FROM_MEM, 5'd15);
    tick();
    chk("pre_rst_data", o_mem_data, 32'h1234_5678);
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_mem_data", o_mem_data, 32'h0);
    chk("arst_alu_data", o_alu_data, 32'h0);
    chk("arst_reg_write", {31'h0, o_reg_write}, 32'h0);
    chk("arst_rd_addr", {27'h0, o_rd_addr}, 32'h0);
    chk("arst_m2r", {31'h0, o_mem_to_reg}, 32'h0);
    chk("arst_dbg", o_debug_data, 32'h1234_5678);
    #2;
    i_reset = 1'b1;
    tick();
    chk("post_rst_lw", o_mem_data, 32'h1234_5678);
    chk("post_rst_rw", {31'h0, o_reg_write}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
